// File: rtl/piso_serializer_if.sv
// Parallel word in, serial bit out bundle between a word producer and piso_serializer.
// The master side offers words and watches the serial stream; the slave side is the serializer.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             so;
    logic             so_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output din, din_valid,
        input  din_ready, so, so_valid, word_done, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, so, so_valid, word_done, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage with a one-word holding buffer feeding a bit shifter.
// Latency: word accepted at edge N shows its first bit after N+1, its last bit after N+WIDTH.
// Backpressure: din_ready is the inverted buffer-full register; a full buffer stalls the producer.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              clear,
    piso_serializer_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             so_q, so_d;

    logic accept;
    logic at_last;
    logic load;

    // Ready depends only on buf_full_q, so accept and load can never coincide.
    assign accept  = bus.din_valid && !buf_full_q;
    assign at_last = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_BIT);
    assign load    = buf_full_q && ((state_q == ST_IDLE) || at_last);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        sh_d       = sh_q;
        so_d       = so_q;

        if (load) begin
            state_d    = ST_SHIFT;
            bit_cnt_d  = '0;
            buf_full_d = 1'b0;
            if (MSB_FIRST) begin
                so_d = buf_q[WIDTH-1];
                sh_d = buf_q << 1;
            end else begin
                so_d = buf_q[0];
                sh_d = buf_q >> 1;
            end
        end else if (state_q == ST_SHIFT) begin
            if (at_last) begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                so_d      = 1'b0;
                sh_d      = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (MSB_FIRST) begin
                    so_d = sh_q[WIDTH-1];
                    sh_d = sh_q << 1;
                end else begin
                    so_d = sh_q[0];
                    sh_d = sh_q >> 1;
                end
            end
        end

        if (accept) begin
            buf_d      = bus.din;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            sh_q       <= '0;
            so_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            sh_q       <= sh_d;
            so_q       <= so_d;
        end
    end

    assign bus.din_ready = !buf_full_q;
    assign bus.so        = so_q;
    assign bus.so_valid  = (state_q == ST_SHIFT);
    assign bus.word_done = at_last;
    assign bus.busy      = (state_q == ST_SHIFT) || buf_full_q;
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first instance sharing clock and reset.
module tb_piso_serializer;
    logic clk;
    logic clear;

    piso_serializer_if #(.WIDTH(8)) m_if ();
    piso_serializer_if #(.WIDTH(8)) l_if ();

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .clear(clear), .bus(m_if));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .clear(clear), .bus(l_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    logic [7:0] words [0:2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit lsb, input logic [7:0] d, input logic v);
        if (lsb) begin
            l_if.din = d;
            l_if.din_valid = v;
        end else begin
            m_if.din = d;
            m_if.din_valid = v;
        end
    endtask

    task automatic observe(input bit lsb, output logic so, output logic sv, output logic wd,
                           output logic rdy, output logic bz);
        if (lsb) begin
            so = l_if.so; sv = l_if.so_valid; wd = l_if.word_done; rdy = l_if.din_ready; bz = l_if.busy;
        end else begin
            so = m_if.so; sv = m_if.so_valid; wd = m_if.word_done; rdy = m_if.din_ready; bz = m_if.busy;
        end
    endtask

    task automatic check_idle(input bit lsb, input string tag);
        logic so, sv, wd, rdy, bz;
        observe(lsb, so, sv, wd, rdy, bz);
        chk({tag, ".so"}, 32'(so), 0);
        chk({tag, ".so_valid"}, 32'(sv), 0);
        chk({tag, ".word_done"}, 32'(wd), 0);
        chk({tag, ".busy"}, 32'(bz), 0);
        chk({tag, ".din_ready"}, 32'(rdy), 1);
    endtask

    // After edge k, hand the producer its next word once the current one has been taken.
    // Word j is accepted at edge 0 (j=0) or (j-1)*8+2 (j>=1).
    task automatic update_drive(input bit lsb, input int n, input int k);
        for (int j = 0; j < n; j++) begin
            if (k == ((j == 0) ? 0 : (j - 1) * 8 + 2)) begin
                if (j + 1 < n) drive(lsb, words[j+1], 1'b1);
                else           drive(lsb, 8'h00, 1'b0);
            end
        end
    endtask

    task automatic run_stream(input bit lsb, input int n, input string tag);
        logic so, sv, wd, rdy, bz;
        logic exp_bit, exp_rdy;
        int j, b;
        drive(lsb, words[0], 1'b1);
        tick();
        observe(lsb, so, sv, wd, rdy, bz);
        chk($sformatf("%s.acc.din_ready", tag), 32'(rdy), 0);
        chk($sformatf("%s.acc.busy", tag), 32'(bz), 1);
        chk($sformatf("%s.acc.so_valid", tag), 32'(sv), 0);
        update_drive(lsb, n, 0);
        for (int k = 1; k <= n * 8; k++) begin
            tick();
            observe(lsb, so, sv, wd, rdy, bz);
            j = (k - 1) / 8;
            b = (k - 1) % 8;
            exp_bit = lsb ? words[j][b] : words[j][7-b];
            exp_rdy = 1'b1;
            for (int i = 1; i < n; i++)
                if (((i - 1) * 8 + 2 <= k) && (k < i * 8 + 1)) exp_rdy = 1'b0;
            chk($sformatf("%s.e%0d.so", tag, k), 32'(so), 32'(exp_bit));
            chk($sformatf("%s.e%0d.so_valid", tag, k), 32'(sv), 1);
            chk($sformatf("%s.e%0d.word_done", tag, k), 32'(wd), (b == 7) ? 1 : 0);
            chk($sformatf("%s.e%0d.din_ready", tag, k), 32'(rdy), 32'(exp_rdy));
            update_drive(lsb, n, k);
        end
        tick();
        check_idle(lsb, {tag, ".end"});
    endtask

    initial begin
        logic so, sv, wd, rdy, bz;

        // Reset asserted from time zero with words offered on both instances.
        clear = 1'b0;
        drive(1'b0, 8'hFF, 1'b1);
        drive(1'b1, 8'hFF, 1'b1);
        #1;
        check_idle(1'b0, "rst0.msb");
        check_idle(1'b1, "rst0.lsb");
        tick();
        check_idle(1'b0, "rst_edge.msb");
        check_idle(1'b1, "rst_edge.lsb");
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        clear = 1'b1;
        tick();
        check_idle(1'b0, "post_rst.msb");

        words[0] = 8'hA5;
        run_stream(1'b0, 1, "single_msb");

        words[0] = 8'hA5; words[1] = 8'h3C;
        run_stream(1'b0, 2, "b2b_msb");

        words[0] = 8'hC3; words[1] = 8'h5A; words[2] = 8'h96;
        run_stream(1'b0, 3, "bp_msb");

        words[0] = 8'hA5;
        run_stream(1'b1, 1, "single_lsb");
        words[0] = 8'h01;
        run_stream(1'b1, 1, "one_lsb");
        words[0] = 8'hB1; words[1] = 8'h0E;
        run_stream(1'b1, 2, "b2b_lsb");

        // Reset during bit 3 of 8'hFF with 8'h00 sitting in the buffer.
        drive(1'b0, 8'hFF, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        tick();
        tick();
        drive(1'b0, 8'h00, 1'b0);
        tick();
        tick();
        observe(1'b0, so, sv, wd, rdy, bz);
        chk("midrst.pre.so", 32'(so), 1);
        chk("midrst.pre.busy", 32'(bz), 1);
        chk("midrst.pre.din_ready", 32'(rdy), 0);
        clear = 1'b0;
        #1;
        check_idle(1'b0, "midrst.async");
        drive(1'b0, 8'h77, 1'b1);
        tick();
        check_idle(1'b0, "midrst.held");
        drive(1'b0, 8'h00, 1'b0);
        clear = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check_idle(1'b0, $sformatf("midrst.after%0d", k));
        end
        words[0] = 8'h5A;
        run_stream(1'b0, 1, "after_rst_msb");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in serial-out stage that sits directly upstream of the serial-in serial-out shift register and drives its `si` input. It accepts WIDTH-bit words over a valid/ready handshake and parks each word in a one-word holding buffer. It then shifts the word out one bit per clock. Back-to-back words stream with no idle bit between them.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32.
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
clear  input  1  asynchronous, active-low reset.
din  input  WIDTH  parallel word to serialize.
din_valid  input  1  din holds a valid word.
din_ready  output  1  the block can accept a word this cycle.
so  output  1  serial data, registered; feeds the downstream `si`.
so_valid  output  1  high while `so` carries a data bit.
word_done  output  1  high during the cycle the last bit of a word is on `so`.
busy  output  1  shifter active or buffer occupied.

Behaviour:
- Reset: `clear` low forces these values immediately, with no wait for a clock edge:
  - shifter = 0, bit counter = 0, buffer empty, state IDLE;
  - so = 0, so_valid = 0, word_done = 0, busy = 0, din_ready = 1.
  - While `clear` is low, no transfer occurs regardless of din_valid.
  - The first edge that can accept a word is the first rising edge after `clear` deasserts.
- Reset mid-word: the word in flight and any buffered word are discarded, with no partial completion and no word_done pulse.
- din_ready = NOT buf_full, driven from a register with no combinational path from din_valid.
- Accept: a word transfers on a rising edge where din_valid AND din_ready are both high.
  - din is captured into the buffer and buf_full sets.
  - din may change freely after that edge.
- Load: on a rising edge where buf_full = 1 AND (state = IDLE OR (state = SHIFT AND bit_cnt = WIDTH-1)):
  - the shifter loads from the buffer, buf_full clears, bit_cnt = 0, state = SHIFT;
  - `so` takes the first bit (per MSB_FIRST) on that same edge.
- Accept and load never occur on the same edge, because din_ready is low whenever the buffer is full.
- Shift: in SHIFT with bit_cnt < WIDTH-1, each edge advances to the next bit and increments bit_cnt.
- Latency: word accepted at edge N gives its first bit on `so` after edge N+1 and its last bit after edge N+WIDTH.
- Stream: word A accepted at edge N, word B offered continuously. B is accepted at edge N+2 and loads at edge N+WIDTH+1, so `so_valid` stays high across the A-to-B boundary.
- Last bit: when bit_cnt = WIDTH-1 and the buffer is empty, the next edge sets state = IDLE, so = 0, so_valid = 0.
- so_valid = 1 exactly while state = SHIFT.
- word_done = 1 exactly while state = SHIFT AND bit_cnt = WIDTH-1. It is combinational from registers, with no extra register stage.
- busy = (state = SHIFT) OR buf_full.
- Backpressure: while buf_full = 1, din_valid held high is ignored, and din must remain stable until din_ready returns high.
- States:
  - IDLE -> SHIFT on load.
  - SHIFT -> SHIFT on shift, or on load at the last bit.
  - SHIFT -> IDLE at the last bit with the buffer empty.
- Widths: bit_cnt is $clog2(WIDTH) bits wide and never exceeds WIDTH-1.

Test Plan:
- Reset: pulse clear low mid-simulation -> so = 0, so_valid = 0, word_done = 0, busy = 0, din_ready = 1 immediately, before any clock edge.
- Single word, WIDTH = 8, MSB_FIRST = 1: din = 8'hA5 accepted at edge N -> so = 1,0,1,0,0,1,0,1 after edges N+1..N+8; word_done high only after edge N+8; so_valid low after edge N+9.
- Back-to-back: din_valid held with 8'hA5 then 8'h3C -> 16 contiguous bits 1010_0101_0011_1100; so_valid never drops; word_done pulses twice, 8 cycles apart.
- Backpressure: offer a third word while a word is shifting and another is buffered -> din_ready = 0 until the buffered word loads; the third word is accepted exactly one edge after din_ready rises; no word lost or duplicated.
- MSB_FIRST = 0: din = 8'hA5 -> so = 1,0,1,0,0,1,0,1 (LSB first); din = 8'h01 -> 1 followed by seven 0s.
- Reset mid-word: assert clear during bit 3 of 8'hFF with 8'h00 buffered -> outputs clear at once; after release, idle until a new word arrives; no word_done pulse occurs.
